mem_fu_arbiter: RTL and testbench
=================================

# mem_fu_arbiter

Sequencing and arbitration controller for the memory functional unit. It picks one memory operation per transaction from the three issue slots using round-robin. It holds that operation's operands steady on the address-generation unit (AGU). It then drives the resulting address onto the D-cache request port, waits for load data, and presents the completed result for writeback. It sits between the issue stage and the AGU / D-cache interface; only one memory operation is in flight at a time.

## Interface
- NUM_REQ, 3, number of requesting issue slots
- TAG_W, 6, physical destination tag width

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  slot i holds a memory op
- req_rd / req_wr  in  NUM_REQ each  slot i is load / store
- req_op1 / req_op2 / req_inst  in  NUM_REQ x 32 each  base value, store data, instruction word
- req_dest_tag  in  NUM_REQ x TAG_W  destination physical tag
- req_grant  out  NUM_REQ  one-hot; slot i accepted this cycle
- agu_op1 / agu_op2 / agu_inst  out  32 each  latched operands to AGU
- agu_rd / agu_wr  out  1 each  latched op type to AGU
- agu_addr  in  32  AGU result: op1 + sign-extended S-imm (store) or I-imm (load)
- mem_req_valid  out  1  D-cache request valid
- mem_req_ready  in  1  D-cache accepts request
- mem_req_addr  out  32  equals agu_addr
- mem_req_wr  out  1  1 = store
- mem_req_wdata  out  32  latched op2
- mem_resp_valid  in  1  load data return
- mem_resp_data  in  32  load data
- done_valid  out  1  completed op available
- done_ack  in  1  writeback accepts completed op
- done_tag  out  TAG_W  latched destination tag
- done_data  out  32  load data; 0 for stores
- done_is_store  out  1  completed op was a store
- squash  in  1  branch-mispredict kill of the in-flight op
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: may grant a slot.
  - ISSUE: mem_req_valid=1.
  - WAIT: load outstanding.
  - DONE: done_valid=1.
  - DRAIN: squashed load outstanding; response will be discarded.
- Eligible slot:
  - req_valid[i] & (req_rd[i] | req_wr[i]).
  - A slot with neither rd nor wr is never granted.
  - rd & wr together is treated as a store.
- Round-robin:
  - A pointer p (reset 0) marks the highest-priority slot.
  - Search order is p, p+1, ..., mod NUM_REQ.
  - After granting slot g, p <= (g+1) mod NUM_REQ.
  - p is unchanged when nothing is granted.
- IDLE:
  - req_grant is combinational and asserted only in IDLE, only when squash=0.
  - On grant, latch op1, op2, inst, rd, wr and tag, then go to ISSUE.
- ISSUE:
  - mem_req_valid is held with stable addr/wr/wdata until mem_req_ready.
  - On ready: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - On mem_resp_valid, capture mem_resp_data into done_data and go to DONE.
  - mem_resp_valid outside WAIT/DRAIN is ignored.
- DONE:
  - done_valid is held until done_ack, then go to IDLE.
  - No new grant is issued in the ack cycle.
- squash (priority over all other transitions):
  - IDLE: suppresses grant.
  - ISSUE without ready: go to IDLE, request withdrawn.
  - ISSUE with ready, load: go to DRAIN.
  - ISSUE with ready, store: go to IDLE.
  - WAIT: go to DRAIN, or to IDLE if mem_resp_valid is in the same cycle.
  - DRAIN: go to IDLE on mem_resp_valid, with no done.
  - DONE: go to IDLE, done dropped.
- Address arithmetic is performed by the AGU, 32-bit wraparound, no overflow flag.

## Timing
- Reset values:
  - State IDLE, p=0.
  - All outputs 0, including the agu_* and done_* registers.
  - req_grant is 0 when no slot is eligible.
- Registered outputs:
  - agu_*, mem_req_*, done_* and busy come from registers or state.
  - mem_req_addr is combinational from agu_addr.
- Grant at cycle 0 → mem_req_valid at cycle 1.
- Store accepted at cycle k → done_valid at k+1.
- Load accepted at cycle k, response at cycle m ≥ k+1 → done_valid at m+1.
- Minimum latency from grant to done_valid: store 2 cycles, load 3 cycles.
- Throughput: at most one op per (issue + wait + done) sequence. The next grant comes no earlier than the cycle after done_ack.
- Asynchronous reset mid-transaction returns to IDLE immediately. Any outstanding D-cache response after reset is ignored.

## Test plan
- **Store:** slot 1 valid, wr=1, op1=0x1000, S-imm=-4, op2=0xAB, ready at cycle 1.
  - grant=3'b010 at cycle 0.
  - mem_req_addr=0x0FFC, wdata=0xAB at cycle 1.
  - done_valid with is_store=1 at cycle 2.
- **Load:**
  - Setup: slot 0, rd=1, op1=0xFFFFFFF0, I-imm=0x20, tag=5; ready delayed 2 cycles; resp=0xDEADBEEF 3 cycles later.
  - Address must be 0x00000010 (wrap), stable while waiting.
  - done_tag=5, done_data=0xDEADBEEF.
- **Round-robin:** all 3 slots continuously valid; grants must follow 001, 010, 100, 001.
- **Backpressure:** done_ack withheld 4 cycles.
  - done_valid/data must stay stable.
  - No grant while withheld; grant is allowed the cycle after the ack.
- **Squash:**
  - In WAIT, then resp: DRAIN, no done_valid, return to IDLE.
  - In ISSUE without ready: mem_req_valid drops next cycle.
- **Reset:** assert reset during WAIT, then deliver a stray resp. All outputs are 0, and no done_valid follows.

Source files
------------

// File: rtl/mem_fu_arbiter.sv
// Memory functional-unit sequencer: round-robin pick of one issue slot, then
// AGU hold, D-cache request, load wait and writeback handshake, one op in flight.
//
// state | meaning
// IDLE  | may grant an eligible slot
// ISSUE | mem_req_valid held until mem_req_ready
// WAIT  | load accepted, waiting for mem_resp_valid
// DONE  | done_valid held until done_ack
// DRAIN | squashed load outstanding, response will be discarded
module mem_fu_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 6
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_rd,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ-1:0][31:0]        req_op1,
  input  logic [NUM_REQ-1:0][31:0]        req_op2,
  input  logic [NUM_REQ-1:0][31:0]        req_inst,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_dest_tag,
  output logic [NUM_REQ-1:0]              req_grant,
  output logic [31:0]                     agu_op1,
  output logic [31:0]                     agu_op2,
  output logic [31:0]                     agu_inst,
  output logic                            agu_rd,
  output logic                            agu_wr,
  input  logic [31:0]                     agu_addr,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [31:0]                     mem_req_addr,
  output logic                            mem_req_wr,
  output logic [31:0]                     mem_req_wdata,
  input  logic                            mem_resp_valid,
  input  logic [31:0]                     mem_resp_data,
  output logic                            done_valid,
  input  logic                            done_ack,
  output logic [TAG_W-1:0]                done_tag,
  output logic [31:0]                     done_data,
  output logic                            done_is_store,
  input  logic                            squash,
  output logic                            busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [31:0]        agu_op1_q, agu_op1_d;
  logic [31:0]        agu_op2_q, agu_op2_d;
  logic [31:0]        agu_inst_q, agu_inst_d;
  logic               agu_rd_q, agu_rd_d;
  logic               agu_wr_q, agu_wr_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TAG_W-1:0]   done_tag_q, done_tag_d;
  logic [31:0]        done_data_q, done_data_d;
  logic               done_is_store_q, done_is_store_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_vec;
  logic [PW-1:0]      pick_idx;
  logic               pick_found;
  logic               grant_en;

  assign eligible = req_valid & (req_rd | req_wr);

  // Search starts at the pointer and wraps; first eligible slot wins.
  always_comb begin
    pick_vec   = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [PW-1:0] cand;
      cand = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_found && eligible[cand]) begin
        pick_found     = 1'b1;
        pick_idx       = cand;
      end
    end
    if (pick_found) pick_vec[pick_idx] = 1'b1;
  end

  assign grant_en  = (state_q == ST_IDLE) && !squash && pick_found;
  assign req_grant = grant_en ? pick_vec : '0;

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    agu_op1_d       = agu_op1_q;
    agu_op2_d       = agu_op2_q;
    agu_inst_d      = agu_inst_q;
    agu_rd_d        = agu_rd_q;
    agu_wr_d        = agu_wr_q;
    tag_d           = tag_q;
    done_tag_d      = done_tag_q;
    done_data_d     = done_data_q;
    done_is_store_d = done_is_store_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_en) begin
          agu_op1_d  = req_op1[pick_idx];
          agu_op2_d  = req_op2[pick_idx];
          agu_inst_d = req_inst[pick_idx];
          // rd together with wr is handled as a store
          agu_wr_d   = req_wr[pick_idx];
          agu_rd_d   = req_rd[pick_idx] & ~req_wr[pick_idx];
          tag_d      = req_dest_tag[pick_idx];
          ptr_d      = PW'((int'(pick_idx) + 1) % NUM_REQ);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (squash) begin
          state_d = (mem_req_ready && !agu_wr_q) ? ST_DRAIN : ST_IDLE;
        end else if (mem_req_ready) begin
          if (agu_wr_q) begin
            done_tag_d      = tag_q;
            done_data_d     = '0;
            done_is_store_d = 1'b1;
            state_d         = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (squash) begin
          state_d = mem_resp_valid ? ST_IDLE : ST_DRAIN;
        end else if (mem_resp_valid) begin
          done_tag_d      = tag_q;
          done_data_d     = mem_resp_data;
          done_is_store_d = 1'b0;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: begin
        if (squash || done_ack) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (mem_resp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      agu_op1_q       <= '0;
      agu_op2_q       <= '0;
      agu_inst_q      <= '0;
      agu_rd_q        <= 1'b0;
      agu_wr_q        <= 1'b0;
      tag_q           <= '0;
      done_tag_q      <= '0;
      done_data_q     <= '0;
      done_is_store_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      agu_op1_q       <= agu_op1_d;
      agu_op2_q       <= agu_op2_d;
      agu_inst_q      <= agu_inst_d;
      agu_rd_q        <= agu_rd_d;
      agu_wr_q        <= agu_wr_d;
      tag_q           <= tag_d;
      done_tag_q      <= done_tag_d;
      done_data_q     <= done_data_d;
      done_is_store_q <= done_is_store_d;
    end
  end

  assign agu_op1       = agu_op1_q;
  assign agu_op2       = agu_op2_q;
  assign agu_inst      = agu_inst_q;
  assign agu_rd        = agu_rd_q;
  assign agu_wr        = agu_wr_q;
  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_req_addr  = agu_addr;
  assign mem_req_wr    = agu_wr_q;
  assign mem_req_wdata = agu_op2_q;
  assign done_valid    = (state_q == ST_DONE);
  assign done_tag      = done_tag_q;
  assign done_data     = done_data_q;
  assign done_is_store = done_is_store_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_fu_arbiter.sv
// Directed bench for mem_fu_arbiter with a behavioural AGU (op1 + I/S immediate)
// and hand-computed expectations.
module tb_mem_fu_arbiter;

  logic              clock = 1'b0;
  logic              reset;
  logic [2:0]        req_valid, req_rd, req_wr;
  logic [2:0][31:0]  req_op1, req_op2, req_inst;
  logic [2:0][5:0]   req_dest_tag;
  logic [2:0]        req_grant;
  logic [31:0]       agu_op1, agu_op2, agu_inst;
  logic              agu_rd, agu_wr;
  logic [31:0]       agu_addr;
  logic              mem_req_valid, mem_req_ready, mem_req_wr;
  logic [31:0]       mem_req_addr, mem_req_wdata;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_data;
  logic              done_valid, done_ack, done_is_store;
  logic [5:0]        done_tag;
  logic [31:0]       done_data;
  logic              squash, busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ST_INST = 32'hFE002E23;  // sw, S-imm = -4
  localparam logic [31:0] LD_INST = 32'h02002003;  // lw, I-imm = 0x20

  mem_fu_arbiter #(.NUM_REQ(3), .TAG_W(6)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_rd(req_rd), .req_wr(req_wr),
    .req_op1(req_op1), .req_op2(req_op2), .req_inst(req_inst),
    .req_dest_tag(req_dest_tag), .req_grant(req_grant),
    .agu_op1(agu_op1), .agu_op2(agu_op2), .agu_inst(agu_inst),
    .agu_rd(agu_rd), .agu_wr(agu_wr), .agu_addr(agu_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wr(mem_req_wr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .done_valid(done_valid), .done_ack(done_ack), .done_tag(done_tag),
    .done_data(done_data), .done_is_store(done_is_store),
    .squash(squash), .busy(busy)
  );

  always #5 clock = ~clock;

  always_comb begin
    logic [31:0] imm;
    if (agu_wr) imm = {{20{agu_inst[31]}}, agu_inst[31:25], agu_inst[11:7]};
    else        imm = {{20{agu_inst[31]}}, agu_inst[31:20]};
    agu_addr = agu_op1 + imm;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rr_exp [4];
    logic [5:0] rr_tag [4];
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    rr_tag = '{6'd1, 6'd2, 6'd3, 6'd1};

    reset = 1'b1; req_valid = '0; req_rd = '0; req_wr = '0;
    req_op1 = '0; req_op2 = '0; req_inst = '0; req_dest_tag = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    done_ack = 0; squash = 0;
    step(); step();
    chk("rst_grant", 32'(req_grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_valid", 32'(mem_req_valid), 0);
    chk("rst_done_valid", 32'(done_valid), 0);
    chk("rst_agu_op1", agu_op1, 0);
    chk("rst_done_data", done_data, 0);
    reset = 1'b0;
    step();

    // round-robin with all three slots holding stores
    req_valid = 3'b111; req_wr = 3'b111; req_rd = 3'b000;
    req_inst = {ST_INST, ST_INST, ST_INST};
    req_dest_tag = {6'd3, 6'd2, 6'd1};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", 32'(req_grant), 32'(rr_exp[i]));
      step();
      mem_req_ready = 1;
      #1;
      chk("rr_issue_valid", 32'(mem_req_valid), 1);
      step();
      mem_req_ready = 0;
      chk("rr_done_tag", 32'(done_tag), 32'(rr_tag[i]));
      done_ack = 1;
      #1;
      chk("rr_ack_nogrant", 32'(req_grant), 0);
      step();
      done_ack = 0;
    end
    req_valid = '0; req_wr = '0;

    // store from slot 1 (pointer is at 1)
    req_valid = 3'b010; req_wr = 3'b010;
    req_op1[1] = 32'h1000; req_op2[1] = 32'hAB; req_inst[1] = ST_INST; req_dest_tag[1] = 6'd3;
    #1;
    chk("st_grant", 32'(req_grant), 32'b010);
    step();
    req_valid = '0;
    #1;
    chk("st_mem_valid", 32'(mem_req_valid), 1);
    chk("st_addr", mem_req_addr, 32'h0000_0FFC);
    chk("st_wdata", mem_req_wdata, 32'hAB);
    chk("st_wr", 32'(mem_req_wr), 1);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("st_done_valid", 32'(done_valid), 1);
    chk("st_is_store", 32'(done_is_store), 1);
    chk("st_done_data", done_data, 0);
    chk("st_done_tag", 32'(done_tag), 3);
    done_ack = 1;
    step();
    done_ack = 0; req_wr = '0;
    chk("st_after_ack", 32'(done_valid), 0);
    chk("st_idle", 32'(busy), 0);

    // load from slot 0 (pointer is at 2, wraps to 0), address wraps
    req_valid = 3'b001; req_rd = 3'b001;
    req_op1[0] = 32'hFFFF_FFF0; req_inst[0] = LD_INST; req_dest_tag[0] = 6'd5;
    #1;
    chk("ld_grant", 32'(req_grant), 32'b001);
    step();
    req_valid = '0;
    #1;
    chk("ld_addr0", mem_req_addr, 32'h0000_0010);
    chk("ld_mem_valid0", 32'(mem_req_valid), 1);
    chk("ld_wr", 32'(mem_req_wr), 0);
    step();
    chk("ld_addr1", mem_req_addr, 32'h0000_0010);
    chk("ld_mem_valid1", 32'(mem_req_valid), 1);
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("ld_wait_memvalid", 32'(mem_req_valid), 0);
    chk("ld_wait_busy", 32'(busy), 1);
    chk("ld_wait_done", 32'(done_valid), 0);
    step(); step();
    chk("ld_wait_done2", 32'(done_valid), 0);
    mem_resp_valid = 1; mem_resp_data = 32'hDEAD_BEEF;
    step();
    mem_resp_valid = 0; mem_resp_data = '0;
    chk("ld_done_valid", 32'(done_valid), 1);
    chk("ld_done_tag", 32'(done_tag), 5);
    chk("ld_done_data", done_data, 32'hDEAD_BEEF);
    chk("ld_is_store", 32'(done_is_store), 0);

    // backpressure: ack withheld four cycles with all slots waiting
    req_valid = 3'b111; req_rd = 3'b111;
    req_inst = {LD_INST, LD_INST, LD_INST};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_nogrant", 32'(req_grant), 0);
      chk("bp_done_valid", 32'(done_valid), 1);
      chk("bp_done_data", done_data, 32'hDEAD_BEEF);
      step();
    end
    done_ack = 1;
    #1;
    chk("bp_ack_nogrant", 32'(req_grant), 0);
    step();
    done_ack = 0;
    #1;
    chk("bp_grant_after_ack", 32'(req_grant), 32'b010);
    step();

    // squash in ISSUE without ready withdraws the request
    req_valid = '0; squash = 1;
    #1;
    chk("sq_issue_valid", 32'(mem_req_valid), 1);
    step();
    squash = 0;
    chk("sq_issue_dropped", 32'(mem_req_valid), 0);
    chk("sq_issue_idle", 32'(busy), 0);

    // squash in WAIT, then the response is drained
    req_valid = 3'b100; req_rd = 3'b100;
    req_op1[2] = 32'h100; req_dest_tag[2] = 6'd9;
    #1;
    chk("sqw_grant", 32'(req_grant), 32'b100);
    step();
    req_valid = '0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("sqw_wait_busy", 32'(busy), 1);
    squash = 1;
    step();
    squash = 0;
    chk("sqw_drain_busy", 32'(busy), 1);
    chk("sqw_drain_done", 32'(done_valid), 0);
    step();
    chk("sqw_drain_hold", 32'(busy), 1);
    mem_resp_valid = 1; mem_resp_data = 32'h1234;
    step();
    mem_resp_valid = 0;
    chk("sqw_idle", 32'(busy), 0);
    chk("sqw_no_done", 32'(done_valid), 0);
    step();
    chk("sqw_no_done2", 32'(done_valid), 0);

    // ineligible slot and squash-suppressed grant (pointer at 0)
    req_valid = 3'b001; req_rd = 3'b000; req_wr = 3'b000;
    #1;
    chk("inelig_nogrant", 32'(req_grant), 0);
    req_rd = 3'b001; squash = 1;
    #1;
    chk("sq_idle_nogrant", 32'(req_grant), 0);
    squash = 0;
    #1;
    chk("sq_idle_grant", 32'(req_grant), 32'b001);

    // reset during WAIT, then a stray response
    req_op1[0] = 32'h40; req_dest_tag[0] = 6'd7;
    step();
    req_valid = '0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    chk("rw_wait_busy", 32'(busy), 1);
    reset = 1;
    #1;
    chk("rw_busy", 32'(busy), 0);
    chk("rw_mem_valid", 32'(mem_req_valid), 0);
    chk("rw_agu_op1", agu_op1, 0);
    chk("rw_agu_inst", agu_inst, 0);
    chk("rw_agu_rd", 32'(agu_rd), 0);
    chk("rw_done_tag", 32'(done_tag), 0);
    chk("rw_done_data", done_data, 0);
    chk("rw_done_valid", 32'(done_valid), 0);
    step();
    reset = 0; mem_resp_valid = 1; mem_resp_data = 32'hCAFE_F00D;
    step();
    mem_resp_valid = 0;
    chk("rw_stray_done", 32'(done_valid), 0);
    chk("rw_stray_busy", 32'(busy), 0);
    step();
    chk("rw_stray_done2", 32'(done_valid), 0);
    chk("rw_stray_data", done_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
